// File: rtl/pwm_timer_bank.sv
// Multi-channel PWM generator: one shared prescaler and period counter, per-channel
// compare/polarity, with all configuration shadowed and reloaded only at period boundaries.
module pwm_timer_bank #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Enable,
    input  logic                      Mode,
    input  logic [WIDTH-1:0]          Prescaler,
    input  logic [WIDTH-1:0]          Period,
    input  logic [CHANNELS*WIDTH-1:0] Duty,
    input  logic [CHANNELS-1:0]       Polarity,
    output logic [CHANNELS-1:0]       PwmOut,
    output logic                      PeriodEnd,
    output logic [WIDTH-1:0]          Count
);

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    logic [WIDTH-1:0]                 pcnt, pcnt_n;
    logic [WIDTH-1:0]                 cnt, cnt_n;
    dir_t                             dir, dir_n;
    logic                             mode_s;
    logic [WIDTH-1:0]                 per_s;
    logic [WIDTH-1:0]                 pre_s;
    logic [CHANNELS-1:0][WIDTH-1:0]   duty_s;
    logic [CHANNELS-1:0]              pol_s;
    logic [CHANNELS-1:0]              pwm_n;
    logic                             pe_n;
    logic                             tick;
    logic                             boundary;
    logic                             load;

    always_comb begin
        tick     = (pcnt == pre_s);
        pcnt_n   = pcnt;
        cnt_n    = cnt;
        dir_n    = dir;
        boundary = 1'b0;
        load     = 1'b0;
        pwm_n    = pol_s;
        pe_n     = 1'b0;

        if (!Enable) begin
            pcnt_n = '0;
            cnt_n  = '0;
            dir_n  = DIR_UP;
            load   = 1'b1;
        end else begin
            pcnt_n = tick ? '0 : pcnt + WIDTH'(1);
            if (tick) begin
                if (per_s == '0) begin
                    boundary = 1'b1;
                end else if (!mode_s) begin
                    if (cnt >= per_s) boundary = 1'b1;
                    else              cnt_n    = cnt + WIDTH'(1);
                end else if (dir == DIR_UP) begin
                    cnt_n = cnt + WIDTH'(1);
                    if (cnt_n == per_s) dir_n = DIR_DOWN;
                end else begin
                    cnt_n = cnt - WIDTH'(1);
                    if (cnt_n == '0) boundary = 1'b1;
                end
            end
            // A boundary restarts the period from zero counting up, so a mode switch starts clean.
            if (boundary) begin
                cnt_n = '0;
                dir_n = DIR_UP;
                load  = 1'b1;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pwm_n[i] = (cnt < duty_s[i]) ^ pol_s[i];
            end
            pe_n = boundary;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt      <= '0;
            cnt       <= '0;
            dir       <= DIR_UP;
            mode_s    <= 1'b0;
            per_s     <= '0;
            pre_s     <= '0;
            duty_s    <= '0;
            pol_s     <= '0;
            PwmOut    <= '0;
            PeriodEnd <= 1'b0;
        end else begin
            pcnt      <= pcnt_n;
            cnt       <= cnt_n;
            dir       <= dir_n;
            PwmOut    <= pwm_n;
            PeriodEnd <= pe_n;
            if (load) begin
                mode_s <= Mode;
                per_s  <= Period;
                pre_s  <= Prescaler;
                duty_s <= Duty;
                pol_s  <= Polarity;
            end
        end
    end

    assign Count = cnt;

endmodule

// File: tb/tb_pwm_timer_bank.sv
// Bench for pwm_timer_bank: directed scenarios plus random configuration churn, checked
// every cycle against a phase-within-period reference model.
module tb_pwm_timer_bank;

    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           mode;
    logic [W-1:0]   pre;
    logic [W-1:0]   per;
    logic [C*W-1:0] duty;
    logic [C-1:0]   pol;
    logic [C-1:0]   pwm_out;
    logic           period_end;
    logic [W-1:0]   count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_timer_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .CLK       (clk),
        .RST       (rst),
        .Enable    (en),
        .Mode      (mode),
        .Prescaler (pre),
        .Period    (per),
        .Duty      (duty),
        .Polarity  (pol),
        .PwmOut    (pwm_out),
        .PeriodEnd (period_end),
        .Count     (count)
    );

    // Reference state: position (in CLKs) inside the current period plus the active config.
    int       phase;
    int       m_mode, m_per, m_pre;
    int       m_duty [C];
    logic [C-1:0] m_pol;
    logic [C-1:0] e_pwm;
    logic     e_pe;
    int       e_cnt;

    function automatic int period_len();
        if (m_per == 0) return m_pre + 1;
        if (m_mode != 0) return 2 * m_per * (m_pre + 1);
        return (m_per + 1) * (m_pre + 1);
    endfunction

    function automatic int cnt_at(input int ph);
        int k;
        k = ph / (m_pre + 1);
        if (m_mode == 0 || m_per == 0) return k;
        return (k <= m_per) ? k : 2 * m_per - k;
    endfunction

    task automatic load_cfg();
        m_mode = int'(mode);
        m_per  = int'(per);
        m_pre  = int'(pre);
        for (int i = 0; i < C; i++) m_duty[i] = int'(duty[i*W +: W]);
        m_pol  = pol;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int c;
        @(posedge clk);
        if (rst) begin
            phase  = 0;
            m_mode = 0; m_per = 0; m_pre = 0; m_pol = '0;
            for (int i = 0; i < C; i++) m_duty[i] = 0;
            e_pwm  = '0;
            e_pe   = 1'b0;
        end else if (!en) begin
            e_pwm = m_pol;
            e_pe  = 1'b0;
            phase = 0;
            load_cfg();
        end else begin
            c = cnt_at(phase);
            for (int i = 0; i < C; i++) e_pwm[i] = (c < m_duty[i]) ^ m_pol[i];
            if (phase == period_len() - 1) begin
                e_pe  = 1'b1;
                phase = 0;
                load_cfg();
            end else begin
                e_pe  = 1'b0;
                phase = phase + 1;
            end
        end
        e_cnt = cnt_at(phase);
        #1;
        check("count",      32'(count),      32'(e_cnt));
        check("pwm_out",    32'(pwm_out),    32'(e_pwm));
        check("period_end", 32'(period_end), 32'(e_pe));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_duty(input int ch, input int val);
        duty[ch*W +: W] = W'(val);
    endtask

    initial begin
        // Reset held with Enable high and live config on the inputs
        rst = 1'b1; en = 1'b1; mode = 1'b0;
        pre = 8'd1; per = 8'd9; duty = '1; pol = '1;
        phase = 0;
        run(3);
        rst = 1'b0;

        // Edge-aligned: ch0 partial duty, ch1 never, ch2 always, ch3 inverted
        en = 1'b0;
        set_duty(0, 3); set_duty(1, 0); set_duty(2, 10); set_duty(3, 5);
        pol = 4'b1000;
        run(2);
        en = 1'b1;
        run(65);

        // Mid-period shadow updates: duty, then period, then mode
        set_duty(0, 7);
        run(45);
        per = 8'd4;
        run(30);
        mode = 1'b1;
        run(40);

        // Centre-aligned from a clean start
        en = 1'b0; mode = 1'b1; pre = 8'd0; per = 8'd8;
        set_duty(0, 2); set_duty(1, 9); set_duty(2, 8); set_duty(3, 0);
        pol = 4'b0010;
        run(1);
        en = 1'b1;
        run(50);

        // Zero period, then maximum prescaler with the smallest non-zero period
        per = 8'd0; pre = 8'd2; mode = 1'b0;
        run(20);
        mode = 1'b1;
        run(10);
        pre = 8'hFF; per = 8'd1; mode = 1'b0;
        run(1030);
        mode = 1'b1;
        run(1100);

        // Enable drop mid-period and restart
        pre = 8'd1; per = 8'd9; mode = 1'b0;
        set_duty(0, 3); pol = 4'b0101;
        run(530);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(47);

        // Random configuration churn, including mid-period input changes and resets
        for (int seg = 0; seg < 30; seg++) begin
            mode = 1'($urandom_range(0, 1));
            per  = W'($urandom_range(0, 12));
            pre  = W'($urandom_range(0, 3));
            for (int i = 0; i < C; i++) set_duty(i, $urandom_range(0, 14));
            pol  = C'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            rst  = ($urandom_range(0, 14) == 0);
            run(1);
            rst  = 1'b0;
            run($urandom_range(5, 70));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
